secirq_escalator: RTL and testbench

//  Consumes the irq8 vector from the security subsystem (mesh, sensor, glue-chain alarms).
//  - Edge-detects each source, latches it as sticky pending and counts events per source.
//  - A timeout/threshold FSM escalates unserviced alarms, then locks out.
//  - Sits between secsub and the CPU interrupt / reset-control logic; lockout feeds the system reset request.

---
 rtl/secirq_escalator.sv | 141 ++++++++++++++
 tb/tb_secirq_escalator.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secirq_escalator.sv
// Security alarm aggregator: edge-detects irq8 sources into sticky pending bits and
// saturating event counters, and escalates unserviced alarms through ALERT/ESCALATE to LOCK.
module secirq_escalator #(
    parameter int NSRC    = 8,
    parameter int CNTW    = 8,
    parameter int ESCTHR  = 4,
    parameter int ESCTMO  = 1024,
    parameter int ESCHOLD = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC-1:0]      irq8,
    input  logic [NSRC-1:0]      irqen,
    input  logic [NSRC-1:0]      clr,
    input  logic                 cntclr,
    input  logic                 ack,
    output logic [NSRC-1:0]      pending,
    output logic [NSRC*CNTW-1:0] evtcnt,
    output logic                 irq,
    output logic                 escalate,
    output logic                 lockout,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALERT    = 2'd1,
        ESCALATE = 2'd2,
        LOCK     = 2'd3
    } state_t;

    localparam int TMR_MAX = (ESCTMO > ESCHOLD) ? ESCTMO : ESCHOLD;
    localparam int TMRW    = $clog2(TMR_MAX);

    localparam logic [TMRW-1:0] TMO_LAST  = TMRW'(ESCTMO - 1);
    localparam logic [TMRW-1:0] HOLD_LAST = TMRW'(ESCHOLD - 1);
    localparam logic [CNTW-1:0] CNT_MAX   = '1;
    localparam logic [CNTW-1:0] CNT_THR   = CNTW'(ESCTHR);

    logic [NSRC-1:0]      irq8_q, irq8_d;
    logic [NSRC-1:0]      rise_q, rise_d;
    logic [NSRC-1:0]      pending_q, pending_d;
    logic [NSRC*CNTW-1:0] evtcnt_q, evtcnt_d;
    logic [TMRW-1:0]      tmr_q, tmr_d;
    state_t               state_q, state_d;
    logic                 irq_w;
    logic                 thr_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq8_q    <= '0;
            rise_q    <= '0;
            pending_q <= '0;
            evtcnt_q  <= '0;
            tmr_q     <= '0;
            state_q   <= IDLE;
        end else begin
            irq8_q    <= irq8_d;
            rise_q    <= rise_d;
            pending_q <= pending_d;
            evtcnt_q  <= evtcnt_d;
            tmr_q     <= tmr_d;
            state_q   <= state_d;
        end
    end

    // Registered rise stage gives the two-edge input-to-pending latency; set beats clr.
    always_comb begin
        irq8_d    = irq8;
        rise_d    = irq8 & ~irq8_q & irqen;
        pending_d = (pending_q & ~clr) | rise_q;
    end

    always_comb begin
        evtcnt_d = evtcnt_q;
        thr_hit  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (cntclr) begin
                evtcnt_d[i*CNTW +: CNTW] = '0;
            end else if (rise_q[i] && (evtcnt_q[i*CNTW +: CNTW] != CNT_MAX)) begin
                evtcnt_d[i*CNTW +: CNTW] = evtcnt_q[i*CNTW +: CNTW] + CNTW'(1);
            end
            if (evtcnt_q[i*CNTW +: CNTW] >= CNT_THR) begin
                thr_hit = 1'b1;
            end
        end
    end

    assign irq_w = |pending_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                if (irq_w) begin
                    state_d = ALERT;
                    tmr_d   = '0;
                end
            end
            ALERT: begin
                if (thr_hit) begin
                    state_d = ESCALATE;
                    tmr_d   = '0;
                end else if (!irq_w) begin
                    state_d = IDLE;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = ESCALATE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMRW'(1);
                end
            end
            ESCALATE: begin
                // Only ack leaves ESCALATE; clearing pending alone just lets the hold timer run.
                if (ack) begin
                    state_d = irq_w ? ALERT : IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == HOLD_LAST) begin
                    state_d = LOCK;
                end else begin
                    tmr_d = tmr_q + TMRW'(1);
                end
            end
            LOCK: begin
                state_d = LOCK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pending  = pending_q;
    assign evtcnt   = evtcnt_q;
    assign irq      = irq_w;
    assign escalate = (state_q == ESCALATE);
    assign lockout  = (state_q == LOCK);
    assign state    = state_q;

endmodule

// File: tb/tb_secirq_escalator.sv
// Directed bench for secirq_escalator: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_secirq_escalator;

    localparam int NSRC    = 8;
    localparam int CNTW    = 8;
    localparam int ESCTHR  = 4;
    localparam int ESCTMO  = 1024;
    localparam int ESCHOLD = 256;

    localparam int S_PEND  = 0;
    localparam int S_CNT   = 1;
    localparam int S_IRQ   = 2;
    localparam int S_ESC   = 3;
    localparam int S_LOCK  = 4;
    localparam int S_STATE = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NSRC-1:0]      irq8;
    logic [NSRC-1:0]      irqen;
    logic [NSRC-1:0]      clr;
    logic                 cntclr;
    logic                 ack;
    logic [NSRC-1:0]      pending;
    logic [NSRC*CNTW-1:0] evtcnt;
    logic                 irq;
    logic                 escalate;
    logic                 lockout;
    logic [1:0]           state;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [63:0] mon_act;
    int          total = 0;
    int          bad   = 0;
    bit          done  = 1'b0;

    secirq_escalator #(
        .NSRC(NSRC), .CNTW(CNTW), .ESCTHR(ESCTHR), .ESCTMO(ESCTMO), .ESCHOLD(ESCHOLD)
    ) dut (
        .clk(clk), .reset(reset), .irq8(irq8), .irqen(irqen), .clr(clr),
        .cntclr(cntclr), .ack(ack), .pending(pending), .evtcnt(evtcnt),
        .irq(irq), .escalate(escalate), .lockout(lockout), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] sample(int sel);
        case (sel)
            S_PEND:  return {56'd0, pending};
            S_CNT:   return evtcnt;
            S_IRQ:   return {63'd0, irq};
            S_ESC:   return {63'd0, escalate};
            S_LOCK:  return {63'd0, lockout};
            default: return {62'd0, state};
        endcase
    endfunction

    // Monitor: drain every expectation queued since the last posedge
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = sample(mon_e.sel);
            total++;
            if (mon_act !== mon_e.val) begin
                bad++;
                $display("[TB] FAIL %s: got %0h expected %0h", mon_e.name, mon_act, mon_e.val);
            end
        end
    end

    initial begin
        #500000;
        if (!done) begin
            $display("[TB] FAIL watchdog: got timeout expected completion");
            $fatal(1, "[TB] watchdog expired");
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string name, input int sel, input logic [63:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic expect_zero(input string pfx);
        expect_out({pfx, "_pend"},  S_PEND,  64'd0);
        expect_out({pfx, "_cnt"},   S_CNT,   64'd0);
        expect_out({pfx, "_irq"},   S_IRQ,   64'd0);
        expect_out({pfx, "_esc"},   S_ESC,   64'd0);
        expect_out({pfx, "_lock"},  S_LOCK,  64'd0);
        expect_out({pfx, "_state"}, S_STATE, 64'd0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        irq8   = '0;
        clr    = '0;
        cntclr = 1'b0;
        ack    = 1'b0;
        irqen  = 8'hFF;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [NSRC-1:0] mask);
        irq8 = mask;
        tick();
        irq8 = '0;
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        irq8   = '0;
        irqen  = 8'hFF;
        clr    = '0;
        cntclr = 1'b0;
        ack    = 1'b0;
        tick(2);
        expect_zero("reset");
        reset = 1'b0;

        // Single held level on source 3: one event, two-edge latency, clr returns to IDLE
        irq8 = 8'h08;
        tick();
        expect_out("t1_pend_early", S_PEND, 64'h00);
        tick();
        expect_out("t1_pend",     S_PEND,  64'h08);
        expect_out("t1_cnt",      S_CNT,   64'h0000_0000_0100_0000);
        expect_out("t1_irq",      S_IRQ,   64'd1);
        expect_out("t1_idle_yet", S_STATE, 64'd0);
        tick();
        expect_out("t1_alert", S_STATE, 64'd1);
        tick(7);
        expect_out("t1_one_event", S_CNT, 64'h0000_0000_0100_0000);
        irq8 = '0;
        clr  = 8'h08;
        tick();
        clr = '0;
        expect_out("t1_clr_pend", S_PEND, 64'h00);
        tick();
        expect_out("t1_back_idle", S_STATE, 64'd0);
        expect_out("t1_irq_low",   S_IRQ,   64'd0);

        // Unserviced pending: timeout to ESCALATE, hold to LOCK, LOCK is sticky
        cntclr = 1'b1;
        tick();
        cntclr = 1'b0;
        expect_out("t2_cntclr", S_CNT, 64'd0);
        pulse(8'h01);
        expect_out("t2_pend",  S_PEND,  64'h01);
        expect_out("t2_idle",  S_STATE, 64'd0);
        tick();
        expect_out("t2_alert", S_STATE, 64'd1);
        tick(ESCTMO - 1);
        expect_out("t2_tmo_last_alert", S_STATE, 64'd1);
        tick();
        expect_out("t2_escalate", S_STATE, 64'd2);
        expect_out("t2_esc_out",  S_ESC,   64'd1);
        tick(ESCHOLD - 1);
        expect_out("t2_hold_last_esc", S_STATE, 64'd2);
        tick();
        expect_out("t2_lock",     S_STATE, 64'd3);
        expect_out("t2_lockout",  S_LOCK,  64'd1);
        expect_out("t2_esc_off",  S_ESC,   64'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick(5);
        expect_out("t2_lock_sticky", S_LOCK, 64'd1);
        pulse(8'h02);
        expect_out("t2_lock_pend", S_PEND, 64'h03);
        expect_out("t2_lock_cnt",  S_CNT,  64'h0000_0000_0000_0101);
        reset = 1'b1;
        tick();
        expect_zero("t2_reset");
        reset = 1'b0;

        // Threshold escalation, ack back to ALERT, immediate re-escalation
        for (int p = 0; p < 4; p++) begin
            pulse(8'h20);
        end
        expect_out("t3_cnt4",  S_CNT,   64'h0000_0400_0000_0000);
        expect_out("t3_alert", S_STATE, 64'd1);
        tick();
        expect_out("t3_thr_esc", S_STATE, 64'd2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        expect_out("t3_ack_alert", S_STATE, 64'd1);
        tick();
        expect_out("t3_reesc", S_STATE, 64'd2);

        // Set-wins and clear-wins collisions
        do_reset();
        irq8 = 8'h04;
        tick();
        clr = 8'h04;
        tick();
        clr = '0;
        expect_out("t4_set_wins", S_PEND, 64'h04);
        expect_out("t4_cnt1",     S_CNT,  64'h0000_0000_0001_0000);
        clr = 8'h04;
        tick();
        clr = '0;
        expect_out("t4_clr", S_PEND, 64'h00);
        irq8 = '0;
        tick();
        irq8 = 8'h04;
        tick();
        cntclr = 1'b1;
        tick();
        cntclr = 1'b0;
        irq8   = '0;
        expect_out("t4_cntclr_wins", S_CNT, 64'd0);

        // Saturation without wrap, then disabled source is ignored
        do_reset();
        for (int p = 1; p <= 300; p++) begin
            pulse(8'h80);
            if (p == 255) expect_out("t5_cnt255", S_CNT, 64'hFF00_0000_0000_0000);
            if (p == 256) expect_out("t5_no_wrap", S_CNT, 64'hFF00_0000_0000_0000);
        end
        expect_out("t5_sat", S_CNT, 64'hFF00_0000_0000_0000);
        irqen  = 8'h7F;
        cntclr = 1'b1;
        clr    = 8'h80;
        tick();
        cntclr = 1'b0;
        clr    = '0;
        expect_out("t5_clr_pend", S_PEND, 64'h00);
        expect_out("t5_clr_cnt",  S_CNT,  64'd0);
        for (int p = 0; p < 3; p++) begin
            pulse(8'h80);
        end
        expect_out("t5_dis_pend", S_PEND, 64'h00);
        expect_out("t5_dis_cnt",  S_CNT,  64'd0);
        irqen = 8'hFF;

        // Reset mid-ESCALATE, then clean edge detection including a level high at release
        do_reset();
        for (int p = 0; p < 4; p++) begin
            pulse(8'h02);
        end
        tick();
        tick(100);
        expect_out("t6_pre_reset", S_STATE, 64'd2);
        reset = 1'b1;
        irq8  = 8'h10;
        tick();
        expect_zero("t6_reset");
        tick();
        reset = 1'b0;
        tick();
        expect_out("t6_pend_early", S_PEND, 64'h00);
        tick();
        expect_out("t6_level_evt", S_PEND, 64'h10);
        expect_out("t6_level_cnt", S_CNT,  64'h0000_0001_0000_0000);
        irq8 = '0;
        tick();
        pulse(8'h02);
        expect_out("t6_restart_pend", S_PEND, 64'h12);
        expect_out("t6_restart_cnt",  S_CNT,  64'h0000_0001_0000_0100);

        @(negedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
